int_tx_fmt: RTL and testbench



---
 rtl/int_tx_pkg.sv | 24 ++
 rtl/int_tx_fmt.sv | 127 ++++++++++++
 tb/tb_int_tx_fmt.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_tx_pkg.sv
// Shared encodings and constants for the decimal ASCII result formatter.
package int_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGN,
        S_DIV,
        S_EMIT,
        S_CR,
        S_LF,
        S_FINISH
    } state_t;

    localparam logic [7:0] ASCII_MINUS = 8'd45;
    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_CR    = 8'd13;
    localparam logic [7:0] ASCII_LF    = 8'd10;

    localparam logic [2:0] MAXPOS = 3'd4;

    // Wide enough for 10000, the largest place value a 16-bit result needs.
    localparam logic [16:0] POW [5] = '{17'd10000, 17'd1000, 17'd100, 17'd10, 17'd1};

endpackage

// File: rtl/int_tx_fmt.sv
// Captures an ALU result on START and writes it to the TX FIFO as decimal ASCII
// ('-' if negative, digits without leading zeros, CR, LF) using repeated subtraction.
module int_tx_fmt
    import int_tx_pkg::*;
#(
    parameter int NBIT   = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [NBIT-1:0] RESULT,
    input  logic            FIFO_full,
    output logic [7:0]      data_out,
    output logic            WR_FIFO,
    output logic            BUSY,
    output logic            DONE
);

    localparam int MW = NBIT + 1;

    state_t        state, state_nxt;
    logic [MW-1:0] mag, mag_nxt;
    logic [2:0]    pos, pos_nxt;
    logic [3:0]    digit, digit_nxt;
    logic          started, started_nxt;

    logic          cap_neg;
    logic [MW-1:0] cap_ext;
    logic [MW-1:0] cap_mag;
    logic [16:0]   pow_cur;
    logic [16:0]   mag_wide;

    // The extra magnitude bit lets the most negative value negate without overflow.
    assign cap_neg  = SIGNED && RESULT[NBIT-1];
    assign cap_ext  = {RESULT[NBIT-1], RESULT};
    assign cap_mag  = cap_neg ? ({MW{1'b0}} - cap_ext) : {1'b0, RESULT};
    assign pow_cur  = POW[pos];
    assign mag_wide = 17'(mag);

    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_FINISH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            mag     <= '0;
            pos     <= '0;
            digit   <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            mag     <= mag_nxt;
            pos     <= pos_nxt;
            digit   <= digit_nxt;
            started <= started_nxt;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_nxt   = state;
        mag_nxt     = mag;
        pos_nxt     = pos;
        digit_nxt   = digit;
        started_nxt = started;
        data_out    = '0;
        WR_FIFO     = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    mag_nxt     = cap_mag;
                    pos_nxt     = '0;
                    digit_nxt   = '0;
                    started_nxt = 1'b0;
                    state_nxt   = cap_neg ? S_SIGN : S_DIV;
                end
            end
            S_SIGN: begin
                data_out = ASCII_MINUS;
                WR_FIFO  = ~FIFO_full;
                if (!FIFO_full) state_nxt = S_DIV;
            end
            S_DIV: begin
                if (mag_wide >= pow_cur) begin
                    mag_nxt   = mag - MW'(pow_cur);
                    digit_nxt = digit + 4'd1;
                end else if (digit != 4'd0 || started || pos == MAXPOS) begin
                    state_nxt = S_EMIT;
                end else begin
                    pos_nxt = pos + 3'd1;
                end
            end
            S_EMIT: begin
                data_out = ASCII_ZERO + {4'd0, digit};
                WR_FIFO  = ~FIFO_full;
                if (!FIFO_full) begin
                    started_nxt = 1'b1;
                    digit_nxt   = '0;
                    if (pos == MAXPOS) begin
                        state_nxt = S_CR;
                    end else begin
                        pos_nxt   = pos + 3'd1;
                        state_nxt = S_DIV;
                    end
                end
            end
            S_CR: begin
                data_out = ASCII_CR;
                WR_FIFO  = ~FIFO_full;
                if (!FIFO_full) state_nxt = S_LF;
            end
            S_LF: begin
                data_out = ASCII_LF;
                WR_FIFO  = ~FIFO_full;
                if (!FIFO_full) state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_tx_fmt.sv
// Scoreboard bench for int_tx_fmt: expected characters are queued at stimulus
// time and popped by a monitor on every FIFO write strobe.
module tb_int_tx_fmt;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START, FIFO_full;
    logic [7:0] RESULT;
    logic [7:0] data_out;
    logic       WR_FIFO, BUSY, DONE;

    logic       start_u, full_u;
    logic [7:0] result_u;
    logic [7:0] data_u;
    logic       wr_u, busy_u, done_u;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int done_cnt = 0;
    int done_exp = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_uq[$];

    always #5 CLK = ~CLK;

    int_tx_fmt #(.NBIT(8), .SIGNED(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .RESULT(RESULT),
        .FIFO_full(FIFO_full), .data_out(data_out), .WR_FIFO(WR_FIFO),
        .BUSY(BUSY), .DONE(DONE)
    );

    int_tx_fmt #(.NBIT(8), .SIGNED(1'b0)) dut_u (
        .CLK(CLK), .RESET_N(RESET_N), .START(start_u), .RESULT(result_u),
        .FIFO_full(full_u), .data_out(data_u), .WR_FIFO(wr_u),
        .BUSY(busy_u), .DONE(done_u)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        logic [7:0] e;
        if (WR_FIFO) begin
            writes++;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_write", int'(data_out), -1);
            end else begin
                e = exp_q.pop_front();
                check(data_out == e, "char", int'(data_out), int'(e));
            end
        end
        if (DONE) done_cnt++;
    end

    always @(negedge CLK) begin
        logic [7:0] e;
        if (wr_u) begin
            if (exp_uq.size() == 0) begin
                check(1'b0, "unexpected_write_u", int'(data_u), -1);
            end else begin
                e = exp_uq.pop_front();
                check(data_u == e, "char_u", int'(data_u), int'(e));
            end
        end
    end

    task automatic push_line(input logic [47:0] s, input int n, input bit uns);
        for (int i = n - 1; i >= 0; i--) begin
            if (uns) exp_uq.push_back(s[8*i +: 8]);
            else     exp_q.push_back(s[8*i +: 8]);
        end
    endtask

    task automatic pulse(input logic [7:0] r);
        @(posedge CLK); #1;
        RESULT = r;
        START  = 1'b1;
        @(posedge CLK); #1;
        START  = 1'b0;
        RESULT = ~r;
        done_exp++;
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!DONE && cyc < 300);
        check(DONE == 1'b1, {name, "_done_seen"}, int'(DONE), 1);
    endtask

    task automatic after_line(input string name);
        @(negedge CLK);
        check(BUSY == 1'b0, {name, "_busy_after"}, int'(BUSY), 0);
        check(done_cnt == done_exp, {name, "_done_count"}, done_cnt, done_exp);
        check(exp_q.size() == 0, {name, "_chars_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int k;
        int w0;
        int bad;

        START = 1'b0; RESULT = '0; FIFO_full = 1'b0;
        start_u = 1'b0; result_u = '0; full_u = 1'b0;

        #12;
        check(BUSY == 1'b0 && DONE == 1'b0, "reset_busy_done", int'({BUSY, DONE}), 0);
        check(WR_FIFO == 1'b0 && data_out == 8'd0, "reset_wr_data", int'(data_out), 0);
        check(busy_u == 1'b0 && wr_u == 1'b0, "reset_u", int'({busy_u, wr_u}), 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // 5: four skipped zeros, five subtracts, fall-through, EMIT, CR, LF, FINISH
        push_line({"5", 8'd13, 8'd10}, 3, 1'b0);
        pulse(8'd5);
        wait_done("r5", cyc);
        check(cyc == 14, "latency_5", cyc, 14);
        after_line("r5");

        push_line({"-10", 8'd13, 8'd10}, 5, 1'b0);
        pulse(8'hF6);
        wait_done("rm10", cyc);
        after_line("rm10");

        push_line({"-128", 8'd13, 8'd10}, 6, 1'b0);
        pulse(8'h80);
        wait_done("rm128", cyc);
        after_line("rm128");

        push_line({"0", 8'd13, 8'd10}, 3, 1'b0);
        pulse(8'h00);
        wait_done("r0", cyc);
        after_line("r0");

        // Back-pressure while the '4' of 42 is being presented
        push_line({"42", 8'd13, 8'd10}, 4, 1'b0);
        pulse(8'd42);
        for (k = 0; k < 60 && data_out != 8'd52; k++) begin
            @(posedge CLK); #1;
        end
        check(data_out == 8'd52, "emit4_reached", int'(data_out), 52);
        FIFO_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check(WR_FIFO == 1'b0, "full_no_write", int'(WR_FIFO), 0);
            check(data_out == 8'd52, "full_hold_char", int'(data_out), 52);
            @(posedge CLK); #1;
        end
        FIFO_full = 1'b0;
        wait_done("r42", cyc);
        after_line("r42");

        // START while busy and START in the FINISH cycle are both ignored
        push_line({"100", 8'd13, 8'd10}, 5, 1'b0);
        pulse(8'd100);
        repeat (3) @(posedge CLK);
        #1;
        START = 1'b1; RESULT = 8'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done("r100", cyc);
        START = 1'b1; RESULT = 8'd9;
        @(posedge CLK); #1;
        START = 1'b0;
        after_line("r100");
        bad = 0;
        repeat (30) begin
            @(negedge CLK);
            if (BUSY || DONE) bad++;
        end
        check(bad == 0, "idle_after_ignored_starts", bad, 0);

        // Reset asserted right after the first character is written
        push_line({"100", 8'd13, 8'd10}, 5, 1'b0);
        pulse(8'd100);
        done_exp--;
        w0 = writes;
        for (k = 0; k < 60 && writes == w0; k++) begin
            @(posedge CLK); #1;
        end
        check(writes == w0 + 1, "first_write_before_reset", writes - w0, 1);
        RESET_N = 1'b0;
        exp_q.delete();
        #1;
        check(BUSY == 1'b0 && WR_FIFO == 1'b0, "async_reset_idle", int'({BUSY, WR_FIFO}), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge CLK);
            if (BUSY || DONE) bad++;
        end
        check(bad == 0, "quiet_after_reset", bad, 0);
        check(writes == w0 + 1, "no_writes_after_reset", writes - w0, 1);

        push_line({"100", 8'd13, 8'd10}, 5, 1'b0);
        pulse(8'd100);
        wait_done("r100b", cyc);
        after_line("r100b");

        // Unsigned instance: 0xFF prints as 255
        push_line({"255", 8'd13, 8'd10}, 5, 1'b1);
        @(posedge CLK); #1;
        result_u = 8'hFF; start_u = 1'b1;
        @(posedge CLK); #1;
        start_u = 1'b0; result_u = 8'h00;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!done_u && cyc < 300);
        check(done_u == 1'b1, "u255_done_seen", int'(done_u), 1);
        @(negedge CLK);
        check(busy_u == 1'b0, "u255_busy_after", int'(busy_u), 0);
        check(exp_uq.size() == 0, "u255_chars_left", exp_uq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
